mipi_dly_cal: RTL and testbench

//  Data-lane IDELAY tap calibration controller for the MIPI deserializer front end.

---
 rtl/mipi_dly_cal.sv | 190 +++++++++++++++++++
 tb/tb_mipi_dly_cal.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mipi_dly_cal.sv
// IDELAY tap calibration for a MIPI data lane: sweeps every tap, scores each one from
// HS start-of-transmission results, then loads the centre of the longest passing run.
module mipi_dly_cal #(
    parameter int TAP_W    = 5,
    parameter int SETTLE   = 64,
    parameter int MIN_HITS = 4,
    parameter int DWELL_W  = 20,
    parameter int MIN_WIN  = 3
) (
    input  logic                  clk,
    input  logic                  resetb,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TAP_W-1:0]      default_tap,
    input  logic                  manual_ld,
    input  logic                  sot_ok,
    input  logic                  sot_err,
    output logic                  del_ld,
    output logic [TAP_W-1:0]      del_val_dat,
    output logic                  busy,
    output logic                  done,
    output logic                  cal_fail,
    output logic [TAP_W-1:0]      best_tap,
    output logic [TAP_W:0]        win_len,
    output logic [2**TAP_W-1:0]   pass_map
);

    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int HIT_W = $clog2(MIN_HITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_MEASURE,
        S_RECORD,
        S_FINAL,
        S_DONE
    } state_t;

    state_t             state;
    logic [TAP_W-1:0]   tap;
    logic [SET_W-1:0]   settle_cnt;
    logic [HIT_W-1:0]   hits;
    logic [DWELL_W-1:0] dwell;
    logic               tap_pass;
    logic [TAP_W:0]     cur_len;
    logic [TAP_W-1:0]   cur_start;
    logic [TAP_W:0]     best_len;
    logic [TAP_W-1:0]   best_start;

    logic [TAP_W:0]     rec_len;
    logic [TAP_W-1:0]   rec_start;
    logic [TAP_W-1:0]   centre;

    // Run-tracker update for the tap being recorded, and the floor centre of the best run.
    always_comb begin
        rec_len   = tap_pass ? cur_len + 1'b1 : '0;
        rec_start = (cur_len == '0) ? tap : cur_start;
        centre    = best_start + TAP_W'((best_len - 1'b1) >> 1);
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state       <= S_IDLE;
            tap         <= '0;
            settle_cnt  <= '0;
            hits        <= '0;
            dwell       <= '0;
            tap_pass    <= 1'b0;
            cur_len     <= '0;
            cur_start   <= '0;
            best_len    <= '0;
            best_start  <= '0;
            del_ld      <= 1'b0;
            del_val_dat <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cal_fail    <= 1'b0;
            best_tap    <= '0;
            win_len     <= '0;
            pass_map    <= '0;
        end else begin
            del_ld <= 1'b0;
            done   <= 1'b0;
            // Abort wins over every sweep state; partial results are left visible.
            if (abort && state != S_IDLE) begin
                del_val_dat <= default_tap;
                del_ld      <= 1'b1;
                busy        <= 1'b0;
                state       <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            pass_map   <= '0;
                            win_len    <= '0;
                            cal_fail   <= 1'b0;
                            cur_len    <= '0;
                            cur_start  <= '0;
                            best_len   <= '0;
                            best_start <= '0;
                            tap        <= '0;
                            busy       <= 1'b1;
                            state      <= S_LOAD;
                        end else if (manual_ld) begin
                            del_val_dat <= default_tap;
                            del_ld      <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        del_val_dat <= tap;
                        del_ld      <= 1'b1;
                        settle_cnt  <= '0;
                        state       <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SET_W'(SETTLE - 1)) begin
                            hits  <= '0;
                            dwell <= '0;
                            state <= S_MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                    S_MEASURE: begin
                        // An error in the same cycle as a sync hit still fails the tap.
                        dwell <= dwell + 1'b1;
                        if (sot_err) begin
                            tap_pass <= 1'b0;
                            state    <= S_RECORD;
                        end else if (sot_ok && hits == HIT_W'(MIN_HITS - 1)) begin
                            hits     <= hits + 1'b1;
                            tap_pass <= 1'b1;
                            state    <= S_RECORD;
                        end else begin
                            if (sot_ok) begin
                                hits <= hits + 1'b1;
                            end
                            if (&dwell) begin
                                tap_pass <= 1'b0;
                                state    <= S_RECORD;
                            end
                        end
                    end
                    S_RECORD: begin
                        if (tap_pass) begin
                            pass_map[tap] <= 1'b1;
                        end
                        cur_len   <= rec_len;
                        cur_start <= rec_start;
                        // Strictly longer only, so the earliest run keeps a tie.
                        if (rec_len > best_len) begin
                            best_len   <= rec_len;
                            best_start <= rec_start;
                            win_len    <= rec_len;
                        end
                        if (&tap) begin
                            state <= S_FINAL;
                        end else begin
                            tap   <= tap + 1'b1;
                            state <= S_LOAD;
                        end
                    end
                    S_FINAL: begin
                        if (best_len >= (TAP_W + 1)'(MIN_WIN)) begin
                            best_tap    <= centre;
                            del_val_dat <= centre;
                            cal_fail    <= 1'b0;
                        end else begin
                            best_tap    <= default_tap;
                            del_val_dat <= default_tap;
                            cal_fail    <= 1'b1;
                        end
                        win_len <= best_len;
                        del_ld  <= 1'b1;
                        state   <= S_DONE;
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mipi_dly_cal.sv
// Randomized bench for mipi_dly_cal: drives sync results per tap from a chosen pass
// pattern and compares the sweep outcome against a run-finding reference model.
module tb_mipi_dly_cal;

    localparam int TAP_W    = 5;
    localparam int NTAPS    = 2**TAP_W;
    localparam int SETTLE   = 8;
    localparam int MIN_HITS = 4;
    localparam int DWELL_W  = 7;
    localparam int MIN_WIN  = 3;

    logic              clk = 1'b0;
    logic              resetb = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [TAP_W-1:0]  default_tap = '0;
    logic              manual_ld = 1'b0;
    logic              sot_ok = 1'b0;
    logic              sot_err = 1'b0;
    logic              del_ld;
    logic [TAP_W-1:0]  del_val_dat;
    logic              busy;
    logic              done;
    logic              cal_fail;
    logic [TAP_W-1:0]  best_tap;
    logic [TAP_W:0]    win_len;
    logic [NTAPS-1:0]  pass_map;

    int num_checks = 0;
    int num_errors = 0;

    mipi_dly_cal #(
        .TAP_W(TAP_W), .SETTLE(SETTLE), .MIN_HITS(MIN_HITS),
        .DWELL_W(DWELL_W), .MIN_WIN(MIN_WIN)
    ) dut (
        .clk(clk), .resetb(resetb), .start(start), .abort(abort),
        .default_tap(default_tap), .manual_ld(manual_ld),
        .sot_ok(sot_ok), .sot_err(sot_err), .del_ld(del_ld),
        .del_val_dat(del_val_dat), .busy(busy), .done(done),
        .cal_fail(cal_fail), .best_tap(best_tap), .win_len(win_len),
        .pass_map(pass_map)
    );

    always #5 clk = ~clk;

    task automatic finishReport();
        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Longest run of passing taps among the first ntaps, earliest run kept on a tie.
    function automatic void refModel(input logic [NTAPS-1:0] pat, input int ntaps,
                                     output int blen, output int bstart);
        int t = 0;
        blen = 0;
        bstart = 0;
        while (t < ntaps) begin
            if (pat[t]) begin
                int s = t;
                while (t < ntaps && pat[t]) t++;
                if (t - s > blen) begin
                    blen = t - s;
                    bstart = s;
                end
            end else begin
                t++;
            end
        end
    endfunction

    task automatic waitLoad(input string tag);
        int limit = 2**DWELL_W + SETTLE + 64;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (del_ld === 1'b1) return;
        end
        checkOutput(tag, 64'd0, 64'd1);
        finishReport();
    endtask

    task automatic pulseOk();
        sot_ok = 1'b1;
        @(negedge clk);
        sot_ok = 1'b0;
    endtask

    // One full sweep; abort_tap < 0 means run to completion.
    task automatic applyStimulus(input logic [NTAPS-1:0] pat, input logic [TAP_W-1:0] dflt,
                                 input bit quiet, input int abort_tap, input int poke_tap);
        int blen, bstart, exp_tap, nk, mode;
        default_tap = dflt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", 64'(busy), 64'd1);
        for (int t = 0; t < NTAPS; t++) begin
            waitLoad("tap_load_timeout");
            checkOutput($sformatf("tap_value_%0d", t), 64'(del_val_dat), 64'(t));
            // Junk results during the settle window must be ignored.
            for (int i = 0; i < SETTLE + 2; i++) begin
                sot_ok  = !quiet && i < SETTLE - 2 && $urandom_range(0, 3) == 0;
                sot_err = !quiet && i < SETTLE - 2 && $urandom_range(0, 3) == 0;
                start   = (t == poke_tap) && i == 1;
                @(negedge clk);
            end
            sot_ok = 1'b0;
            sot_err = 1'b0;
            start = 1'b0;
            if (t == abort_tap) begin
                int seen_done = 0;
                pulseOk();
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                checkOutput("abort_ld", 64'(del_ld), 64'd1);
                checkOutput("abort_val", 64'(del_val_dat), 64'(dflt));
                checkOutput("abort_busy", 64'(busy), 64'd0);
                for (int i = 0; i < 6; i++) begin
                    if (done) seen_done++;
                    @(negedge clk);
                end
                checkOutput("abort_no_done", 64'(seen_done), 64'd0);
                checkOutput("abort_pass_map", 64'(pass_map),
                            64'(pat & ((NTAPS'(1) << t) - 1'b1)));
                return;
            end
            if (pat[t]) begin
                for (int k = 0; k < MIN_HITS; k++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    pulseOk();
                end
            end else if (!quiet) begin
                mode = $urandom_range(0, 2);
                if (mode != 0) begin
                    nk = $urandom_range(0, MIN_HITS - 1);
                    for (int k = 0; k < nk; k++) begin
                        repeat ($urandom_range(0, 3)) @(negedge clk);
                        pulseOk();
                    end
                    sot_err = 1'b1;
                    sot_ok  = (mode == 2);
                    @(negedge clk);
                    sot_err = 1'b0;
                    sot_ok  = 1'b0;
                end
            end
        end
        refModel(pat, NTAPS, blen, bstart);
        exp_tap = (blen >= MIN_WIN) ? bstart + (blen - 1) / 2 : int'(dflt);
        waitLoad("final_load_timeout");
        checkOutput("final_val", 64'(del_val_dat), 64'(exp_tap));
        @(negedge clk);
        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("busy_cleared", 64'(busy), 64'd0);
        checkOutput("best_tap", 64'(best_tap), 64'(exp_tap));
        checkOutput("win_len", 64'(win_len), 64'(blen));
        checkOutput("cal_fail", 64'(cal_fail), 64'(blen < MIN_WIN));
        checkOutput("pass_map", 64'(pass_map), 64'(pat));
        @(negedge clk);
        checkOutput("done_single", 64'(done), 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_del_ld"}, 64'(del_ld), 64'd0);
        checkOutput({tag, "_del_val"}, 64'(del_val_dat), 64'd0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_cal_fail"}, 64'(cal_fail), 64'd0);
        checkOutput({tag, "_best_tap"}, 64'(best_tap), 64'd0);
        checkOutput({tag, "_win_len"}, 64'(win_len), 64'd0);
        checkOutput({tag, "_pass_map"}, 64'(pass_map), 64'd0);
    endtask

    function automatic logic [NTAPS-1:0] randomPattern();
        logic [NTAPS-1:0] p = '0;
        int s, l;
        repeat ($urandom_range(1, 4)) begin
            s = $urandom_range(0, NTAPS - 1);
            l = $urandom_range(1, 9);
            for (int i = s; i < s + l && i < NTAPS; i++) p[i] = 1'b1;
        end
        return p;
    endfunction

    initial begin
        logic [NTAPS-1:0] pat;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        resetb = 1'b1;
        @(negedge clk);

        default_tap = 5'd9;
        manual_ld = 1'b1;
        @(negedge clk);
        manual_ld = 1'b0;
        checkOutput("manual_ld", 64'(del_ld), 64'd1);
        checkOutput("manual_val", 64'(del_val_dat), 64'd9);
        @(negedge clk);
        checkOutput("manual_ld_single", 64'(del_ld), 64'd0);

        applyStimulus('1, 5'd2, 1'b0, -1, 3);
        checkOutput("all_pass_tap", 64'(best_tap), 64'd15);

        pat = '0;
        for (int i = 10; i <= 20; i++) pat[i] = 1'b1;
        applyStimulus(pat, 5'd1, 1'b0, -1, -1);

        pat = '0;
        for (int i = 2; i <= 5; i++) pat[i] = 1'b1;
        for (int i = 20; i <= 23; i++) pat[i] = 1'b1;
        applyStimulus(pat, 5'd0, 1'b0, -1, -1);
        checkOutput("tie_earliest", 64'(best_tap), 64'd3);

        pat = '0;
        pat[4] = 1'b1;
        pat[5] = 1'b1;
        applyStimulus(pat, 5'd7, 1'b0, -1, -1);

        applyStimulus('0, 5'd12, 1'b1, -1, -1);

        applyStimulus(randomPattern(), 5'd21, 1'b0, 9, -1);

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sot_ok = 1'b1;
        repeat (150) @(negedge clk);
        #2 resetb = 1'b0;
        #1 checkResetState("midreset");
        sot_ok = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 4; n++) begin
            applyStimulus(randomPattern(), 5'($urandom_range(0, NTAPS - 1)), 1'b0, -1,
                          int'($urandom_range(0, NTAPS - 1)));
        end

        finishReport();
    end

endmodule
